// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared types for the PC sequencer: return FSM state encoding
//                and the stack push/pop direction encoding carried on
//                s_pushpop.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    // Return-sequence FSM states
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        RET_POP  = 2'd1,
        RET_LOAD = 2'd2
    } pcseq_state_t;

    // s_pushpop encoding
    localparam logic PUSH = 1'b0;
    localparam logic POP  = 1'b1;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/stack_depth_ctr.sv
`default_nettype none
// ============================================================================
//  Module      : stack_depth_ctr
//  Description : Saturating 0..NWORDS occupancy counter for the call stack.
//                inc is ignored when full, dec is ignored when empty.
//  Ports       : clk   - system clock
//                reset - asynchronous active-low reset (clears depth)
//                inc   - count one push
//                dec   - count one pop
//                depth - current entry count
//                full  - depth == NWORDS
//                empty - depth == 0
//  Revision    : 1.0 - initial release
// ============================================================================
module stack_depth_ctr #(
    parameter int NWORDS  = 16,
    parameter int DEPTH_W = $clog2(NWORDS) + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               inc,
    input  logic               dec,
    output logic [DEPTH_W-1:0] depth,
    output logic               full,
    output logic               empty
);

    localparam logic [DEPTH_W-1:0] c_max = DEPTH_W'(NWORDS);

    logic [DEPTH_W-1:0] r_depth;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_depth <= '0;
        end else if (inc && !dec && (r_depth != c_max)) begin
            r_depth <= r_depth + 1'b1;
        end else if (dec && !inc && (r_depth != '0)) begin
            r_depth <= r_depth - 1'b1;
        end
    end

    assign depth = r_depth;
    assign full  = (r_depth == c_max);
    assign empty = (r_depth == '0);

endmodule : stack_depth_ctr
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : pc_sequencer
//  Description : Program counter sequencer with jump/call/ret and an external
//                call stack. A call pushes PC+1 in the accepting cycle; a ret
//                takes three cycles (RUN -> RET_POP -> RET_LOAD). Stack
//                overflow/underflow set sticky flags.
//  Config      : PCSEQ_ERR_TRAP_EN - when defined, a stack error loads pc with
//                TRAP_VEC; otherwise pc advances to pc+1.
//  Ports       : clk, reset (async active-low), stall, jump, call, ret,
//                target, stack_rdata (inputs);
//                pc, we_stack, s_pushpop, stack_wdata, depth, busy,
//                ovf_err, unf_err (outputs)
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer
    import cpu_pkg::*;
#(
    parameter int WIDTH    = 10,
    parameter int NWORDS   = 16,
    parameter int TRAP_VEC = 0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        stall,
    input  logic                        jump,
    input  logic                        call,
    input  logic                        ret,
    input  logic [WIDTH-1:0]            target,
    input  logic [WIDTH-1:0]            stack_rdata,
    output logic [WIDTH-1:0]            pc,
    output logic                        we_stack,
    output logic                        s_pushpop,
    output logic [WIDTH-1:0]            stack_wdata,
    output logic [$clog2(NWORDS):0]     depth,
    output logic                        busy,
    output logic                        ovf_err,
    output logic                        unf_err
);

    localparam int DEPTH_W = $clog2(NWORDS) + 1;

`ifdef PCSEQ_ERR_TRAP_EN
    localparam bit c_use_trap = 1'b1;
`else
    localparam bit c_use_trap = 1'b0;
`endif
    localparam logic [WIDTH-1:0] c_trap_vec = WIDTH'(TRAP_VEC);

    pcseq_state_t       r_state;
    pcseq_state_t       w_state_next;
    logic [WIDTH-1:0]   r_pc;
    logic [WIDTH-1:0]   w_pc_next;
    logic [WIDTH-1:0]   w_pc_inc;
    logic [WIDTH-1:0]   w_err_pc;
    logic               r_ovf;
    logic               r_unf;
    logic               w_set_ovf;
    logic               w_set_unf;
    logic               w_push;
    logic               w_pop;
    logic               w_full;
    logic               w_empty;

    // Natural WIDTH-bit truncation gives the modulo-2^WIDTH wrap.
    assign w_pc_inc = r_pc + 1'b1;
    assign w_err_pc = c_use_trap ? c_trap_vec : w_pc_inc;

    stack_depth_ctr #(
        .NWORDS  (NWORDS),
        .DEPTH_W (DEPTH_W)
    ) u_depth (
        .clk   (clk),
        .reset (reset),
        .inc   (w_push),
        .dec   (w_pop),
        .depth (depth),
        .full  (w_full),
        .empty (w_empty)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= RUN;
            r_pc    <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            r_ovf   <= r_ovf | w_set_ovf;
            r_unf   <= r_unf | w_set_unf;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_push       = 1'b0;
        w_pop        = 1'b0;
        w_set_ovf    = 1'b0;
        w_set_unf    = 1'b0;

        // A stalled cycle holds everything, including a pending pop, so the
        // pop strobe can only fire in the single unstalled RET_POP cycle.
        if (!stall) begin
            case (r_state)
                RUN: begin
                    if (ret) begin
                        if (!w_empty) begin
                            w_state_next = RET_POP;
                        end else begin
                            w_set_unf = 1'b1;
                            w_pc_next = w_err_pc;
                        end
                    end else if (call) begin
                        if (!w_full) begin
                            w_push    = 1'b1;
                            w_pc_next = target;
                        end else begin
                            w_set_ovf = 1'b1;
                            w_pc_next = w_err_pc;
                        end
                    end else if (jump) begin
                        w_pc_next = target;
                    end else begin
                        w_pc_next = w_pc_inc;
                    end
                end
                RET_POP: begin
                    w_pop        = 1'b1;
                    w_state_next = RET_LOAD;
                end
                RET_LOAD: begin
                    // Stack data is valid the cycle after the pop strobe.
                    w_pc_next    = stack_rdata;
                    w_state_next = RUN;
                end
                default: begin
                    w_state_next = RUN;
                end
            endcase
        end
    end

    assign pc          = r_pc;
    assign we_stack    = w_push | w_pop;
    assign s_pushpop   = w_pop ? POP : PUSH;
    assign stack_wdata = w_pc_inc;
    assign busy        = (r_state != RUN);
    assign ovf_err     = r_ovf;
    assign unf_err     = r_unf;

endmodule : pc_sequencer
`default_nettype wire
